// File: rtl/cpi_crop_pack.sv
// CPI pixel-domain front end: crops a row/column window, packs two pixels per word, queues words.
// Optional build macro CPI_CROP_DECIM_EN adds cfg_decim_i for 2:1 horizontal/vertical decimation.
module cpi_crop_pack #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cfg_en_i,
  input  logic                    cfg_clr_i,
  input  logic [CNT_WIDTH-1:0]    cfg_col_start_i,
  input  logic [CNT_WIDTH-1:0]    cfg_col_end_i,
  input  logic [CNT_WIDTH-1:0]    cfg_row_start_i,
  input  logic [CNT_WIDTH-1:0]    cfg_row_end_i,
`ifdef CPI_CROP_DECIM_EN
  input  logic                    cfg_decim_i,
`endif
  input  logic [DATA_WIDTH-1:0]   cam_data_i,
  input  logic                    cam_hsync_i,
  input  logic                    cam_vsync_i,
  output logic [2*DATA_WIDTH-1:0] data_o,
  output logic                    sof_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    overflow_o
);

  localparam int WW = 2 * DATA_WIDTH;
  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DROP} state_e;

  typedef struct packed {
    logic          sof;
    logic [WW-1:0] data;
  } fifo_ent_t;

  state_e                state_q;
  logic                  vsync_q, hsync_q;
  logic [CNT_WIDTH-1:0]  col_q, row_q;
  logic                  half_q, half_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic                  sof_pend_q, sof_pend_d;
  logic                  overflow_q;
  fifo_ent_t             mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q;

  logic      sof_evt, eol_evt, line_act, in_win, decim_ok, keep;
  logic      push_req, push_ok, pop, full, ovf_evt;
  fifo_ent_t push_ent;

  assign sof_evt  = vsync_q & ~cam_vsync_i;
  assign eol_evt  = hsync_q & ~cam_hsync_i;
  assign line_act = cam_hsync_i & ~cam_vsync_i;

  // An inverted window (start > end) can never satisfy both bounds, so it keeps nothing.
  assign in_win = (col_q >= cfg_col_start_i) && (col_q <= cfg_col_end_i) &&
                  (row_q >= cfg_row_start_i) && (row_q <= cfg_row_end_i);

`ifdef CPI_CROP_DECIM_EN
  logic [CNT_WIDTH-1:0] col_off, row_off;
  assign col_off  = col_q - cfg_col_start_i;
  assign row_off  = row_q - cfg_row_start_i;
  assign decim_ok = ~cfg_decim_i | (~col_off[0] & ~row_off[0]);
`else
  assign decim_ok = 1'b1;
`endif

  assign keep    = (state_q == ACTIVE) && cfg_en_i && line_act && in_win && decim_ok;
  assign valid_o = (cnt_q != '0);
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign pop     = valid_o & ready_i;
  assign push_ok = push_req & ~cfg_clr_i & (~full | pop);
  assign ovf_evt = push_req & ~cfg_clr_i & full & ~pop;

  always_comb begin
    push_req   = 1'b0;
    push_ent   = '0;
    half_d     = half_q;
    lo_d       = lo_q;
    sof_pend_d = sof_pend_q;
    if (keep) begin
      if (half_q) begin
        push_req      = 1'b1;
        push_ent.data = {cam_data_i, lo_q};
        half_d        = 1'b0;
      end else begin
        lo_d   = cam_data_i;
        half_d = 1'b1;
      end
    end else if (eol_evt && half_q) begin
      // Odd pixel count on a line: flush the lone pixel with a zero upper byte.
      push_req      = 1'b1;
      push_ent.data = {{DATA_WIDTH{1'b0}}, lo_q};
      half_d        = 1'b0;
    end
    push_ent.sof = sof_pend_q;
    if (push_req) sof_pend_d = 1'b0;
    if (sof_evt) begin
      sof_pend_d = 1'b1;
      half_d     = 1'b0;
    end
    if (ovf_evt || !cfg_en_i || cfg_clr_i) half_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vsync_q    <= 1'b0;
      hsync_q    <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      half_q     <= 1'b0;
      lo_q       <= '0;
      sof_pend_q <= 1'b0;
    end else begin
      vsync_q    <= cam_vsync_i;
      hsync_q    <= cam_hsync_i;
      half_q     <= half_d;
      lo_q       <= lo_d;
      sof_pend_q <= sof_pend_d;
      // Counters saturate rather than wrap so an oversized frame never re-enters the window.
      if (eol_evt)                      col_q <= '0;
      else if (line_act && col_q != '1) col_q <= col_q + 1'b1;
      if (sof_evt)                      row_q <= '0;
      else if (eol_evt && row_q != '1)  row_q <= row_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      if (cfg_clr_i)    overflow_q <= 1'b0;
      else if (ovf_evt) overflow_q <= 1'b1;
      if (!cfg_en_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE:     state_q <= WAIT_SOF;
          WAIT_SOF: if (sof_evt) state_q <= ACTIVE;
          ACTIVE:   if (ovf_evt) state_q <= DROP;
          DROP:     if (sof_evt) state_q <= ACTIVE;
          default:  state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (cfg_clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the head is only exposed while valid_o is high.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= push_ent;
  end

  assign data_o     = valid_o ? mem_q[rd_q].data : '0;
  assign sof_o      = valid_o & mem_q[rd_q].sof;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_cpi_crop_pack.sv
// Directed bench for cpi_crop_pack: 8x4 frames with pixel = offset + row*16 + col.
module tb_cpi_crop_pack;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst, en, clr, hs, vs, rdy;
  logic [CW-1:0] cs, ce, rs, re;
  logic [7:0]    cam_d;
  logic [15:0]   dout;
  logic          sof, vld, ovf;
`ifdef CPI_CROP_DECIM_EN
  logic          decim;
`endif

  int errs = 0;
  int checks = 0;
  logic [15:0] gd[$];
  logic        gs[$];

  cpi_crop_pack dut (
    .clk_i(clk), .rst_i(rst), .cfg_en_i(en), .cfg_clr_i(clr),
    .cfg_col_start_i(cs), .cfg_col_end_i(ce), .cfg_row_start_i(rs), .cfg_row_end_i(re),
`ifdef CPI_CROP_DECIM_EN
    .cfg_decim_i(decim),
`endif
    .cam_data_i(cam_d), .cam_hsync_i(hs), .cam_vsync_i(vs),
    .data_o(dout), .sof_o(sof), .valid_o(vld), .ready_i(rdy), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  // Words are recorded on the falling edge, ahead of the rising edge that pops them.
  always @(negedge clk) begin
    if (vld && rdy && !rst) begin
      gd.push_back(dout);
      gs.push_back(sof);
    end
  end

  task automatic drv(input logic v, input logic h, input logic [7:0] d);
    @(posedge clk); #2;
    vs = v; hs = h; cam_d = d;
  endtask

  task automatic set_win(input int c0, input int c1, input int r0, input int r1);
    cs = CW'(c0); ce = CW'(c1); rs = CW'(r0); re = CW'(r1);
  endtask

  task automatic clr_q();
    gd.delete();
    gs.delete();
  endtask

  // er/ec toggles cfg_en, rr/rc toggles ready, when that pixel is driven.
  task automatic send_frame(input logic [7:0] ofs, input int er, input int ec,
                            input int rr, input int rc);
    drv(1, 0, 0); drv(1, 0, 0); drv(0, 0, 0); drv(0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #2;
        if (r == er && c == ec) en = ~en;
        if (r == rr && c == rc) rdy = ~rdy;
        vs = 1'b0; hs = 1'b1; cam_d = 8'(ofs + r * 16 + c);
      end
      repeat (3) drv(0, 0, 0);
    end
    repeat (8) drv(0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; hs = 1'b0; vs = 1'b0; rdy = 1'b1; cam_d = '0;
    set_win(0, 0, 0, 0);
`ifdef CPI_CROP_DECIM_EN
    decim = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2;
    checks++; if (dout !== 16'h0) begin errs++; $display("FAIL reset_data: got %h want 0000", dout); end
    checks++; if (sof !== 1'b0) begin errs++; $display("FAIL reset_sof: got %b want 0", sof); end
    checks++; if (vld !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", vld); end
    checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst = 1'b0;
    drv(0, 0, 0);
  endtask

  task automatic test_window();
    logic [15:0] ew[4] = '{16'h1312, 16'h1514, 16'h2322, 16'h2524};
    logic        es[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    en = 1'b1; rdy = 1'b1; set_win(2, 5, 1, 2); clr_q();
    send_frame(8'h00, -1, -1, -1, -1);
    checks++; if (gd.size() != 4) begin errs++; $display("FAIL window_count: got %0d want 4", gd.size()); end
    for (int i = 0; i < 4 && i < gd.size(); i++) begin
      checks++; if (gd[i] !== ew[i]) begin errs++; $display("FAIL window_word%0d: got %h want %h", i, gd[i], ew[i]); end
      checks++; if (gs[i] !== es[i]) begin errs++; $display("FAIL window_sof%0d: got %b want %b", i, gs[i], es[i]); end
    end
    checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL window_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_eol_flush();
    logic [15:0] ew[2] = '{16'hA1A0, 16'h00A2};
    logic        es[2] = '{1'b1, 1'b0};
    set_win(0, 2, 0, 0); clr_q();
    send_frame(8'hA0, -1, -1, -1, -1);
    checks++; if (gd.size() != 2) begin errs++; $display("FAIL eol_count: got %0d want 2", gd.size()); end
    for (int i = 0; i < 2 && i < gd.size(); i++) begin
      checks++; if (gd[i] !== ew[i]) begin errs++; $display("FAIL eol_word%0d: got %h want %h", i, gd[i], ew[i]); end
      checks++; if (gs[i] !== es[i]) begin errs++; $display("FAIL eol_sof%0d: got %b want %b", i, gs[i], es[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] ew[6] = '{16'h0100, 16'h0302, 16'h0504, 16'h1110, 16'h1312, 16'h1514};
    rdy = 1'b0; set_win(0, 5, 0, 1); clr_q();
    send_frame(8'h00, -1, -1, -1, -1);
    checks++; if (gd.size() != 0) begin errs++; $display("FAIL ovf_stall_count: got %0d want 0", gd.size()); end
    checks++; if (vld !== 1'b1) begin errs++; $display("FAIL ovf_valid: got %b want 1", vld); end
    checks++; if (ovf !== 1'b1) begin errs++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    checks++; if (dout !== 16'h0100) begin errs++; $display("FAIL ovf_head_stable: got %h want 0100", dout); end
    checks++; if (sof !== 1'b1) begin errs++; $display("FAIL ovf_head_sof: got %b want 1", sof); end
    @(posedge clk); #2; rdy = 1'b1;
    repeat (8) drv(0, 0, 0);
    checks++; if (gd.size() != 4) begin errs++; $display("FAIL ovf_drain_count: got %0d want 4", gd.size()); end
    for (int i = 0; i < 4 && i < gd.size(); i++) begin
      checks++; if (gd[i] !== ew[i]) begin errs++; $display("FAIL ovf_drain%0d: got %h want %h", i, gd[i], ew[i]); end
    end
    clr_q();
    send_frame(8'h00, -1, -1, -1, -1);
    checks++; if (gd.size() != 6) begin errs++; $display("FAIL ovf_next_count: got %0d want 6", gd.size()); end
    for (int i = 0; i < 6 && i < gd.size(); i++) begin
      checks++; if (gd[i] !== ew[i]) begin errs++; $display("FAIL ovf_next%0d: got %h want %h", i, gd[i], ew[i]); end
    end
    if (gs.size() > 0) begin
      checks++; if (gs[0] !== 1'b1) begin errs++; $display("FAIL ovf_next_sof: got %b want 1", gs[0]); end
    end
    checks++; if (ovf !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    @(posedge clk); #2; clr = 1'b1;
    @(posedge clk); #2; clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL ovf_clear: got %b want 0", ovf); end
  endtask

  task automatic test_enable();
    en = 1'b0; rdy = 1'b1; set_win(2, 5, 1, 2);
    repeat (2) drv(0, 0, 0);
    clr_q();
    send_frame(8'h00, 1, 0, -1, -1);
    checks++; if (gd.size() != 0) begin errs++; $display("FAIL en_midframe_count: got %0d want 0", gd.size()); end
    checks++; if (en !== 1'b1) begin errs++; $display("FAIL en_hook: got %b want 1", en); end
    clr_q();
    send_frame(8'h00, -1, -1, -1, -1);
    checks++; if (gd.size() != 4) begin errs++; $display("FAIL en_next_count: got %0d want 4", gd.size()); end
    if (gd.size() > 0) begin
      checks++; if (gd[0] !== 16'h1312) begin errs++; $display("FAIL en_next_word: got %h want 1312", gd[0]); end
    end
    rdy = 1'b0; clr_q();
    send_frame(8'h00, 1, 4, 2, 0);
    checks++; if (gd.size() != 1) begin errs++; $display("FAIL en_drop_count: got %0d want 1", gd.size()); end
    if (gd.size() > 0) begin
      checks++; if (gd[0] !== 16'h1312) begin errs++; $display("FAIL en_drop_word: got %h want 1312", gd[0]); end
    end
    en = 1'b1; rdy = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ew[8] = '{16'h0100, 16'h0302, 16'h0504, 16'h0706,
                           16'h1110, 16'h1312, 16'h1514, 16'h1716};
    rdy = 1'b0; set_win(0, 7, 0, 1); clr_q();
    send_frame(8'h00, -1, -1, 1, 1);
    checks++; if (gd.size() != 8) begin errs++; $display("FAIL b2b_count: got %0d want 8", gd.size()); end
    for (int i = 0; i < 8 && i < gd.size(); i++) begin
      checks++; if (gd[i] !== ew[i]) begin errs++; $display("FAIL b2b_word%0d: got %h want %h", i, gd[i], ew[i]); end
    end
    checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
    set_win(6, 3, 0, 3); clr_q();
    send_frame(8'h00, -1, -1, -1, -1);
    checks++; if (gd.size() != 0) begin errs++; $display("FAIL inverted_count: got %0d want 0", gd.size()); end
    checks++; if (vld !== 1'b0) begin errs++; $display("FAIL inverted_valid: got %b want 0", vld); end
  endtask

  task automatic test_reset_mid();
    rdy = 1'b0; set_win(0, 5, 0, 1); clr_q();
    send_frame(8'h00, -1, -1, -1, -1);
    checks++; if (ovf !== 1'b1) begin errs++; $display("FAIL rstmid_pre_ovf: got %b want 1", ovf); end
    drv(1, 0, 0); drv(0, 0, 0); drv(0, 0, 0);
    for (int c = 0; c < 3; c++) drv(0, 1, 8'(c));
    #1 rst = 1'b1;
    #1;
    checks++; if (dout !== 16'h0) begin errs++; $display("FAIL rstmid_data: got %h want 0000", dout); end
    checks++; if (sof !== 1'b0) begin errs++; $display("FAIL rstmid_sof: got %b want 0", sof); end
    checks++; if (vld !== 1'b0) begin errs++; $display("FAIL rstmid_valid: got %b want 0", vld); end
    checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL rstmid_ovf: got %b want 0", ovf); end
    @(posedge clk); #2;
    rst = 1'b0; rdy = 1'b1; hs = 1'b0;
    repeat (2) drv(0, 0, 0);
  endtask

`ifdef CPI_CROP_DECIM_EN
  task automatic test_decim();
    decim = 1'b1; en = 1'b1; rdy = 1'b1; set_win(2, 5, 1, 2); clr_q();
    send_frame(8'h00, -1, -1, -1, -1);
    checks++; if (gd.size() != 1) begin errs++; $display("FAIL decim_count: got %0d want 1", gd.size()); end
    if (gd.size() > 0) begin
      checks++; if (gd[0] !== 16'h1412) begin errs++; $display("FAIL decim_word: got %h want 1412", gd[0]); end
      checks++; if (gs[0] !== 1'b1) begin errs++; $display("FAIL decim_sof: got %b want 1", gs[0]); end
    end
    decim = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_window();
    test_eol_flush();
    test_overflow();
    test_enable();
    test_back_to_back();
    test_reset_mid();
`ifdef CPI_CROP_DECIM_EN
    test_decim();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cpi_crop_pack.md
Name: cpi_crop_pack

Overview:
- Pixel-clock-domain front stage of the CPI receive path. Sits between the camera pad signals and the camera interface's rx data input.
- Extracts a programmable rectangular window from each frame. Packs two 8-bit pixels per 16-bit word.
- Buffers words in a small FIFO and hands them downstream over valid/ready.
- Flags overflow and drops the rest of the frame on overflow.

Parameters:
- DATA_WIDTH, 8, pixel width; output word is 2*DATA_WIDTH.
- CNT_WIDTH, 12, width of the row/column counters and window bounds.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk_i  in  1  camera pixel clock; sole clock.
- rst_i  in  1  asynchronous reset, active-high.
- cfg_en_i  in  1  enable capture.
- cfg_clr_i  in  1  one-cycle pulse; clears overflow_o and flushes the FIFO.
- cfg_col_start_i  in  CNT_WIDTH  first kept column, inclusive.
- cfg_col_end_i  in  CNT_WIDTH  last kept column, inclusive.
- cfg_row_start_i  in  CNT_WIDTH  first kept row, inclusive.
- cfg_row_end_i  in  CNT_WIDTH  last kept row, inclusive.
- cam_data_i  in  DATA_WIDTH  pixel data.
- cam_hsync_i  in  1  line valid; high while pixels are active.
- cam_vsync_i  in  1  frame sync; its falling edge marks start of frame.
- data_o  out  2*DATA_WIDTH  packed word; the earlier pixel is in the low byte.
- sof_o  out  1  high with the first word of a frame.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  downstream accepts the word.
- overflow_o  out  1  sticky overflow flag.

Behaviour:
- Reset values: data_o=0, sof_o=0, valid_o=0, overflow_o=0. FIFO empty, counters 0, FSM in IDLE.
- Edge detection: cam_vsync_i and cam_hsync_i are registered once. sof_evt = registered vsync high and current vsync low. eol_evt = registered hsync high and current hsync low.
- FSM states:
  - IDLE: entered whenever cfg_en_i=0. On cfg_en_i=1, go to WAIT_SOF.
  - WAIT_SOF: on sof_evt, go to ACTIVE. Capture never starts mid-frame.
  - ACTIVE: on an overflow, go to DROP.
  - DROP: on sof_evt, go to ACTIVE. overflow_o stays set.
- Counters:
  - col resets to 0 on eol_evt and increments on each cycle with hsync=1 && vsync=0.
  - row resets to 0 on sof_evt and increments on eol_evt.
- Pixel kept when: state=ACTIVE, hsync=1, vsync=0, col_start<=col<=col_end, and row_start<=row<=row_end. All comparisons are unsigned. If start>end on either axis, nothing is kept.
- Packing:
  - The first kept pixel is held in the low byte.
  - The second kept pixel completes the word, which is pushed on that same cycle.
  - valid_o rises one cycle after the push, so latency from the second pixel to data_o is 1 cycle.
  - On eol_evt with a held half-word, that word is pushed with its upper byte 0. A new line always starts in the low byte.
- sof tag: the first word pushed after each sof_evt carries sof=1. It is stored as a FIFO sideband bit.
- FIFO push: accepted when not full, or when a pop happens in the same cycle.
- FIFO overflow: a push with the FIFO full and no pop discards the word, sets overflow_o, and moves the FSM to DROP. The held half-word is discarded.
- FIFO pop: valid_o && ready_i. data_o and sof_o present the head entry and are stable while valid_o=1 and ready_i=0.
- cfg_en_i deasserted mid-frame: go to IDLE next cycle and discard the held half-word. The FIFO keeps draining.
- cfg_clr_i: empties the FIFO (valid_o=0 next cycle), clears overflow_o, discards the held half-word. The FSM state is unchanged. If cfg_clr_i and a push occur in the same cycle, the clear wins and the word is lost.
- Counter wrap: counters saturate at all-ones. They never wrap.

Optional Feature:
- Macro: CPI_CROP_DECIM_EN.
- With the macro defined:
  - Adds input cfg_decim_i (1 bit).
  - When cfg_decim_i=1, only pixels with (col - col_start) even are kept, giving horizontal 2:1 decimation.
  - Rows with (row - row_start) odd are also dropped.
- Without the macro: the port is absent and every in-window pixel is kept.

Test Plan:
1. Window cols 2..5, rows 1..2, 8x4 frame, pixel value = row*16+col, ready_i=1 -> four words: 0x1312, 0x1514, 0x2322, 0x2524. sof_o=1 only on 0x1312. overflow_o=0.
2. Window cols 0..2, row 0 only, pixels 0xA0,0xA1,0xA2 -> words 0xA1A0 then 0x00A2 (the latter pushed on eol_evt).
3. ready_i=0, window of 12 pixels, FIFO_DEPTH=4 -> 4 words held, overflow_o=1, no further pushes that frame. Then ready_i=1 -> the 4 words drain and the next frame captures normally with overflow_o still 1. cfg_clr_i -> overflow_o=0.
4. cfg_en_i raised mid-frame -> no output until the next vsync falling edge. cfg_en_i dropped mid-line -> no further pushes, queued words still delivered.
5. Full FIFO with ready_i=1 and a push in the same cycle -> word accepted, no overflow. cfg_col_start_i=6, cfg_col_end_i=3 -> no output.
6. With CPI_CROP_DECIM_EN and cfg_decim_i=1, same setup as test 1 -> single word 0x1412. rst_i asserted mid-frame -> all outputs 0 immediately.
